wb_rdwr_arbiter: RTL and testbench

WB_RDWR_ARBITER -- requirements
Module: wb_rdwr_arbiter

---
 rtl/wb_rdwr_arbiter_pkg.sv | 20 ++
 rtl/wb_req_mux.sv | 32 +++
 rtl/wb_rdwr_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_rdwr_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rdwr_arbiter_pkg.sv
// Shared wishbone arbiter types: FSM state encoding and owner-select values.
// Imported by the arbiter top and its payload mux.
package wb_rdwr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_t;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  function automatic logic owner_of(
    input arb_state_t st
  );
    return (st == ST_OWN_B) ? OWNER_B : OWNER_A;
  endfunction

endpackage

// File: rtl/wb_req_mux.sv
// 2:1 wishbone request payload mux.
// Selects we/addr/data/sel from master A or master B.
module wb_req_mux
  import wb_rdwr_arbiter_pkg::*;
#(
  parameter int AW = 26,
  parameter int DW = 32
) (
  input  logic            pick,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_data,
  input  logic [DW/8-1:0] a_sel,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [DW-1:0]   b_data,
  input  logic [DW/8-1:0] b_sel,
  output logic            we,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   data,
  output logic [DW/8-1:0] sel
);

  logic use_b;

  assign use_b = (pick == OWNER_B);
  assign we    = use_b ? b_we   : a_we;
  assign addr  = use_b ? b_addr : a_addr;
  assign data  = use_b ? b_data : a_data;
  assign sel   = use_b ? b_sel  : a_sel;

endmodule

// File: rtl/wb_rdwr_arbiter.sv
// Two-master wishbone arbiter: read bridge A, write bridge B.
// Owner keeps the bus until it drops cyc; ties alternate.
module wb_rdwr_arbiter
  import wb_rdwr_arbiter_pkg::*;
#(
  parameter int AW               = 26,
  parameter int DW               = 32,
  parameter bit OPT_ZERO_ON_IDLE = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_axi_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  arb_state_t state;
  arb_state_t state_nx;
  logic       last_owner;
  logic       last_owner_nx;

  logic            own_a;
  logic            own_b;
  logic            idle;
  logic            mux_we;
  logic [AW-1:0]   mux_addr;
  logic [DW-1:0]   mux_data;
  logic [DW/8-1:0] mux_sel;

  always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
    if (!i_axi_reset_n) begin
      state      <= ST_IDLE;
      last_owner <= OWNER_A;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
    end
  end

  // A wins an idle tie only if B went last; B wins the first tie.
  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    unique case (state)
      ST_IDLE: begin
        if (i_a_cyc &&
            (!i_b_cyc || last_owner == OWNER_B))
          state_nx = ST_OWN_A;
        else if (i_b_cyc)
          state_nx = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (!i_a_cyc)
          state_nx = i_b_cyc ? ST_OWN_B : ST_IDLE;
      end
      ST_OWN_B: begin
        if (!i_b_cyc)
          state_nx = i_a_cyc ? ST_OWN_A : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (state_nx != ST_IDLE)
      last_owner_nx = owner_of(state_nx);
  end

  assign own_a = (state == ST_OWN_A);
  assign own_b = (state == ST_OWN_B);
  assign idle  = !own_a && !own_b;

  always_comb begin
    o_wb_cyc  = 1'b0;
    o_wb_stb  = 1'b0;
    o_a_stall = 1'b1;
    o_b_stall = 1'b1;
    o_a_ack   = 1'b0;
    o_a_err   = 1'b0;
    o_b_ack   = 1'b0;
    o_b_err   = 1'b0;
    unique case (1'b1)
      own_a: begin
        o_wb_cyc  = i_a_cyc;
        o_wb_stb  = i_a_cyc & i_a_stb;
        o_a_stall = i_wb_stall;
        o_a_ack   = i_a_cyc & i_wb_ack;
        o_a_err   = i_a_cyc & i_wb_err;
      end
      own_b: begin
        o_wb_cyc  = i_b_cyc;
        o_wb_stb  = i_b_cyc & i_b_stb;
        o_b_stall = i_wb_stall;
        o_b_ack   = i_b_cyc & i_wb_ack;
        o_b_err   = i_b_cyc & i_wb_err;
      end
      default: ;
    endcase
  end

  wb_req_mux #(
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .pick   (owner_of(state)),
    .a_we   (i_a_we),
    .a_addr (i_a_addr),
    .a_data (i_a_data),
    .a_sel  (i_a_sel),
    .b_we   (i_b_we),
    .b_addr (i_b_addr),
    .b_data (i_b_data),
    .b_sel  (i_b_sel),
    .we     (mux_we),
    .addr   (mux_addr),
    .data   (mux_data),
    .sel    (mux_sel)
  );

  assign o_wb_we = mux_we;

  always_comb begin
    o_wb_addr = mux_addr;
    o_wb_data = mux_data;
    o_wb_sel  = mux_sel;
    if (OPT_ZERO_ON_IDLE && idle) begin
      o_wb_addr = '0;
      o_wb_data = '0;
      o_wb_sel  = '0;
    end
  end

  assign o_rdata = i_wb_data;

endmodule

// File: tb/tb_wb_rdwr_arbiter.sv
// Scoreboard bench for wb_rdwr_arbiter: two instances (idle payload
// kept / zeroed) driven together and checked against an ownership model.
module tb_wb_rdwr_arbiter;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_cyc, a_stb, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic [SW-1:0] a_sel;
  logic          b_cyc, b_stb, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic [SW-1:0] b_sel;
  logic          wb_stall, wb_ack, wb_err;
  logic [DW-1:0] wb_data;

  logic          d0_a_stall, d0_a_ack, d0_a_err;
  logic          d0_b_stall, d0_b_ack, d0_b_err;
  logic [DW-1:0] d0_rdata;
  logic          d0_cyc, d0_stb, d0_we;
  logic [AW-1:0] d0_addr;
  logic [DW-1:0] d0_data;
  logic [SW-1:0] d0_sel;

  logic          d1_a_stall, d1_a_ack, d1_a_err;
  logic          d1_b_stall, d1_b_ack, d1_b_err;
  logic [DW-1:0] d1_rdata;
  logic          d1_cyc, d1_stb, d1_we;
  logic [AW-1:0] d1_addr;
  logic [DW-1:0] d1_data;
  logic [SW-1:0] d1_sel;

  always #5 clk = ~clk;

  wb_rdwr_arbiter #(
    .AW (AW), .DW (DW), .OPT_ZERO_ON_IDLE (1'b0)
  ) dut0 (
    .i_clk (clk), .i_axi_reset_n (rst_n),
    .i_a_cyc (a_cyc), .i_a_stb (a_stb), .i_a_we (a_we),
    .i_a_addr (a_addr), .i_a_data (a_data), .i_a_sel (a_sel),
    .o_a_stall (d0_a_stall), .o_a_ack (d0_a_ack),
    .o_a_err (d0_a_err),
    .i_b_cyc (b_cyc), .i_b_stb (b_stb), .i_b_we (b_we),
    .i_b_addr (b_addr), .i_b_data (b_data), .i_b_sel (b_sel),
    .o_b_stall (d0_b_stall), .o_b_ack (d0_b_ack),
    .o_b_err (d0_b_err),
    .o_rdata (d0_rdata),
    .o_wb_cyc (d0_cyc), .o_wb_stb (d0_stb), .o_wb_we (d0_we),
    .o_wb_addr (d0_addr), .o_wb_data (d0_data),
    .o_wb_sel (d0_sel),
    .i_wb_stall (wb_stall), .i_wb_ack (wb_ack),
    .i_wb_err (wb_err), .i_wb_data (wb_data)
  );

  wb_rdwr_arbiter #(
    .AW (AW), .DW (DW), .OPT_ZERO_ON_IDLE (1'b1)
  ) dut1 (
    .i_clk (clk), .i_axi_reset_n (rst_n),
    .i_a_cyc (a_cyc), .i_a_stb (a_stb), .i_a_we (a_we),
    .i_a_addr (a_addr), .i_a_data (a_data), .i_a_sel (a_sel),
    .o_a_stall (d1_a_stall), .o_a_ack (d1_a_ack),
    .o_a_err (d1_a_err),
    .i_b_cyc (b_cyc), .i_b_stb (b_stb), .i_b_we (b_we),
    .i_b_addr (b_addr), .i_b_data (b_data), .i_b_sel (b_sel),
    .o_b_stall (d1_b_stall), .o_b_ack (d1_b_ack),
    .o_b_err (d1_b_err),
    .o_rdata (d1_rdata),
    .o_wb_cyc (d1_cyc), .o_wb_stb (d1_stb), .o_wb_we (d1_we),
    .o_wb_addr (d1_addr), .o_wb_data (d1_data),
    .o_wb_sel (d1_sel),
    .i_wb_stall (wb_stall), .i_wb_ack (wb_ack),
    .i_wb_err (wb_err), .i_wb_data (wb_data)
  );

  typedef struct {
    bit            own;
    logic          cyc, stb, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] sel;
    logic          a_stall, a_ack, a_err;
    logic          b_stall, b_ack, b_err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   checks  = 0;
  int   miss    = 0;

  // model: 0 = nobody, 1 = A, 2 = B
  int owner = 0;
  int last  = 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      chk("d0_cyc", 64'(d0_cyc), 64'(e.cyc));
      chk("d0_stb", 64'(d0_stb), 64'(e.stb));
      chk("d0_a_stall", 64'(d0_a_stall), 64'(e.a_stall));
      chk("d0_b_stall", 64'(d0_b_stall), 64'(e.b_stall));
      chk("d0_a_ack", 64'(d0_a_ack), 64'(e.a_ack));
      chk("d0_b_ack", 64'(d0_b_ack), 64'(e.b_ack));
      chk("d0_a_err", 64'(d0_a_err), 64'(e.a_err));
      chk("d0_b_err", 64'(d0_b_err), 64'(e.b_err));
      chk("d0_rdata", 64'(d0_rdata), 64'(e.rdata));
      chk("d1_cyc", 64'(d1_cyc), 64'(e.cyc));
      chk("d1_stb", 64'(d1_stb), 64'(e.stb));
      chk("d1_a_stall", 64'(d1_a_stall), 64'(e.a_stall));
      chk("d1_b_stall", 64'(d1_b_stall), 64'(e.b_stall));
      chk("d1_a_ack", 64'(d1_a_ack), 64'(e.a_ack));
      chk("d1_b_ack", 64'(d1_b_ack), 64'(e.b_ack));
      chk("d1_a_err", 64'(d1_a_err), 64'(e.a_err));
      chk("d1_b_err", 64'(d1_b_err), 64'(e.b_err));
      if (e.own) begin
        chk("d0_we", 64'(d0_we), 64'(e.we));
        chk("d0_addr", 64'(d0_addr), 64'(e.addr));
        chk("d0_data", 64'(d0_data), 64'(e.data));
        chk("d0_sel", 64'(d0_sel), 64'(e.sel));
        chk("d1_we", 64'(d1_we), 64'(e.we));
        chk("d1_addr", 64'(d1_addr), 64'(e.addr));
        chk("d1_data", 64'(d1_data), 64'(e.data));
        chk("d1_sel", 64'(d1_sel), 64'(e.sel));
      end else begin
        chk("d1_idle_addr", 64'(d1_addr), 64'd0);
        chk("d1_idle_data", 64'(d1_data), 64'd0);
        chk("d1_idle_sel", 64'(d1_sel), 64'd0);
      end
    end
  end

  // Owner holds while its cyc is up; otherwise pick among requesters,
  // preferring the one that did not own the bus most recently.
  task automatic model_clock();
    bit keep;
    if (rst_n !== 1'b1) return;
    keep = (owner == 1 && a_cyc) || (owner == 2 && b_cyc);
    if (!keep) begin
      if (a_cyc && b_cyc) owner = (last == 1) ? 2 : 1;
      else if (a_cyc)     owner = 1;
      else if (b_cyc)     owner = 2;
      else                owner = 0;
    end
    if (owner != 0) last = owner;
  endtask

  task automatic step(input bit r,
                      input bit ac, input bit as, input bit aw,
                      input bit bc, input bit bs, input bit bw,
                      input bit st, input bit ak, input bit er);
    exp_t x;
    @(posedge clk);
    model_clock();
    #1;
    rst_n    = r;
    a_cyc    = ac; a_stb = as; a_we = aw;
    b_cyc    = bc; b_stb = bs; b_we = bw;
    wb_stall = st; wb_ack = ak; wb_err = er;
    a_addr   = AW'($urandom); a_data = $urandom;
    a_sel    = SW'($urandom);
    b_addr   = AW'($urandom); b_data = $urandom;
    b_sel    = SW'($urandom);
    wb_data  = $urandom;
    if (!r) begin
      owner = 0;
      last  = 1;
    end
    x.own = (owner != 0);
    x.cyc = 0; x.stb = 0; x.we = 0;
    x.addr = '0; x.data = '0; x.sel = '0;
    x.a_stall = 1; x.a_ack = 0; x.a_err = 0;
    x.b_stall = 1; x.b_ack = 0; x.b_err = 0;
    x.rdata = wb_data;
    if (owner == 1) begin
      x.cyc = ac; x.stb = ac & as; x.we = aw;
      x.addr = a_addr; x.data = a_data; x.sel = a_sel;
      x.a_stall = st; x.a_ack = ac & ak; x.a_err = ac & er;
    end else if (owner == 2) begin
      x.cyc = bc; x.stb = bc & bs; x.we = bw;
      x.addr = b_addr; x.data = b_data; x.sel = b_sel;
      x.b_stall = st; x.b_ack = bc & ak; x.b_err = bc & er;
    end
    sb.push_back(x);
  endtask

  initial begin
    bit ac, bc;
    rst_n = 0;
    a_cyc = 0; a_stb = 0; a_we = 0;
    b_cyc = 0; b_stb = 0; b_we = 0;
    a_addr = '0; a_data = '0; a_sel = '0;
    b_addr = '0; b_data = '0; b_sel = '0;
    wb_stall = 0; wb_ack = 0; wb_err = 0; wb_data = '0;

    repeat (2) step(0, 0,0,0, 0,0,0, 0,0,0);
    // A alone: grant after one stalled cycle
    repeat (3) step(1, 1,1,0, 0,0,0, 0,0,0);
    repeat (2) step(1, 0,0,0, 0,0,0, 0,0,0);
    // fresh reset so the tie is the first one
    step(0, 0,0,0, 0,0,0, 0,0,0);
    repeat (3) step(1, 1,1,0, 1,1,1, 0,0,0);
    repeat (3) step(1, 1,1,0, 0,0,0, 0,0,0);
    repeat (2) step(1, 0,0,0, 0,0,0, 0,0,0);
    // A with three outstanding reads, B waiting
    step(1, 1,1,0, 0,0,0, 0,0,0);
    repeat (3) step(1, 1,1,0, 1,1,1, 0,0,0);
    repeat (3) step(1, 1,0,0, 1,1,1, 0,1,0);
    step(1, 0,0,0, 1,1,1, 0,1,0);
    repeat (2) step(1, 0,0,0, 1,1,1, 0,0,0);
    repeat (2) step(1, 0,0,0, 0,0,0, 0,0,0);
    // error to A, then B pending takes over
    repeat (2) step(1, 1,1,0, 1,0,1, 0,0,0);
    step(1, 1,0,0, 1,0,1, 0,0,1);
    step(1, 0,0,0, 1,1,1, 0,0,0);
    step(1, 0,0,0, 1,1,1, 0,0,0);
    repeat (2) step(1, 0,0,0, 0,0,0, 0,0,0);
    // stray responses in idle
    step(1, 0,0,0, 0,0,0, 0,1,0);
    step(1, 0,0,0, 0,0,0, 1,0,1);
    // reset in the middle of a B burst
    repeat (4) step(1, 0,0,0, 1,1,1, 0,1,0);
    step(0, 0,0,0, 1,1,1, 0,1,0);
    step(0, 0,0,0, 0,0,0, 0,0,0);
    repeat (3) step(1, 1,1,0, 0,0,0, 0,0,0);
    repeat (2) step(1, 0,0,0, 0,0,0, 0,0,0);

    ac = 0;
    bc = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 4) == 0) ac = !ac;
      if ($urandom_range(0, 4) == 0) bc = !bc;
      step($urandom_range(0, 99) != 0,
           ac, 1'($urandom), 1'($urandom),
           bc, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom),
           $urandom_range(0, 7) == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      miss++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miss);
    $finish;
  end

endmodule
